fetch_queue: RTL

// - Instruction-fetch stage directly upstream of the execute datapath.
// - Generates the sequential PC, reads 32-bit words from instruction memory, and buffers them in a small FIFO.
// - Hands {inst_data, inst_pc} to decode/execute over a valid/ready handshake.
// - Accepts redirects (branch/jmp/jsr/jsrr) from the datapath and flushes stale work.

---
 rtl/fetch_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: sequential PC generation, one-deep memory pipeline,
// and a small in-order FIFO handed to decode over valid/ready.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int IMEM_AW = 6,
  parameter int PC_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lock,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [PC_W-1:0]            inst_pc,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  req_pc;
  logic             inflight;
  logic             tag;
  logic             epoch;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0]      data_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem   [DEPTH];

  logic [CNT_W:0]   occupancy;
  logic             credit_ok;
  logic             issue;
  logic             push;
  logic             pop;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credits cover both stored entries and the one read still in flight,
  // so a response always has a slot waiting for it.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign credit_ok = occupancy < (CNT_W+1)'(DEPTH);

  assign issue = rst_n && lock && !redirect_valid && credit_ok;
  assign push  = lock && !redirect_valid && inflight && (tag == epoch);
  assign pop   = lock && !redirect_valid && (count != '0) && inst_ready;

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc[IMEM_AW+1:2];
  assign inst_valid = (count != '0);
  assign inst_data  = data_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= '0;
      req_pc   <= '0;
      inflight <= 1'b0;
      tag      <= 1'b0;
      epoch    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (lock) begin
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
        inflight <= 1'b0;
        epoch    <= ~epoch;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          req_pc   <= fetch_pc;
          tag      <= epoch;
          fetch_pc <= fetch_pc + PC_W'(4);
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule
